dram_init_checker: RTL

//  Read-side counterpart of the bucket-header initializer. After init reports Done, it walks every

---
 rtl/dram_init_checker_if.sv | 23 ++
 rtl/dram_init_checker.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dram_init_checker_if.sv
// DRAM command/read-data channel between the header checker (master) and the DDR3 controller (slave).
interface dram_init_checker_if #(
  parameter int DDRAWidth = 28,
  parameter int DDRDWidth = 512,
  parameter int DDRCWidth = 3
);
  logic [DDRAWidth-1:0] cmdAddr;
  logic [DDRCWidth-1:0] cmd;
  logic                 cmdValid;
  logic                 cmdReady;
  logic [DDRDWidth-1:0] readData;
  logic                 readDataValid;

  modport master (
    output cmdAddr, cmd, cmdValid,
    input  cmdReady, readData, readDataValid
  );

  modport slave (
    input  cmdAddr, cmd, cmdValid,
    output cmdReady, readData, readDataValid
  );
endinterface

// File: rtl/dram_init_checker.sv
// dram_init_checker: reads back every bucket header after init and checks its valid bits are zero
// (and its IV field equals IV when DRAMCHECK_IV_EN is defined); reports pass, error count, first bad address.
module dram_init_checker #(
  parameter int                   DDRAWidth       = 28,
  parameter int                   DDRDWidth       = 512,
  parameter int                   DDRCWidth       = 3,
  parameter logic [DDRCWidth-1:0] DDR3CMD_Read    = 3'b001,
  parameter int                   NumBuckets      = 1024,
  parameter int                   BktSize_DRWords = 8,
  parameter int                   IVWidth         = 64,
  parameter int                   ValidBits       = 8,
  parameter logic [IVWidth-1:0]   IV              = '0,
  parameter int                   ErrCntWidth     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  dram_init_checker_if.master    dram,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ErrCntWidth-1:0] errorCount_o,
  output logic [DDRAWidth-1:0]   firstErrAddr_o
);

  localparam int CntWidth = $clog2(NumBuckets + 1);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumBuckets - 1);
  localparam logic [CntWidth-1:0] NumBkt  = CntWidth'(NumBuckets);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cmdCnt_q, cmdCnt_d;
  logic [CntWidth-1:0]    rspCnt_q, rspCnt_d;
  logic [ErrCntWidth-1:0] errCnt_q, errCnt_d;
  logic [DDRAWidth-1:0]   firstErr_q, firstErr_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;

  logic                   cmdValid;
  logic                   cmdFire;
  logic                   rspFire;
  logic                   hdrFail;
  logic                   unusedBits;
  logic [DDRAWidth-1:0]   rspAddr;
  logic [ValidBits-1:0]   validField;

  assign cmdValid = (state_q == StRun) && (cmdCnt_q < NumBkt);
  assign cmdFire  = cmdValid && dram.cmdReady;
  // Data with no outstanding command (rspCnt == cmdCnt) is unsolicited and must not be counted.
  assign rspFire  = (state_q == StRun) && dram.readDataValid && (rspCnt_q != cmdCnt_q);

  assign dram.cmdValid = cmdValid;
  assign dram.cmd      = DDR3CMD_Read;
  assign dram.cmdAddr  = DDRAWidth'(cmdCnt_q) * DDRAWidth'(BktSize_DRWords);
  assign rspAddr       = DDRAWidth'(rspCnt_q) * DDRAWidth'(BktSize_DRWords);

  assign validField = dram.readData[IVWidth+ValidBits-1:IVWidth];

`ifdef DRAMCHECK_IV_EN
  assign hdrFail    = (validField != '0) || (dram.readData[IVWidth-1:0] != IV);
  assign unusedBits = ^dram.readData[DDRDWidth-1:IVWidth+ValidBits];
`else
  assign hdrFail    = (validField != '0);
  assign unusedBits = ^{dram.readData[DDRDWidth-1:IVWidth+ValidBits], dram.readData[IVWidth-1:0], IV};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cmdCnt_q   <= '0;
      rspCnt_q   <= '0;
      errCnt_q   <= '0;
      firstErr_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmdCnt_q   <= cmdCnt_d;
      rspCnt_q   <= rspCnt_d;
      errCnt_q   <= errCnt_d;
      firstErr_q <= firstErr_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmdCnt_d   = cmdCnt_q;
    rspCnt_d   = rspCnt_q;
    errCnt_d   = errCnt_q;
    firstErr_d = firstErr_q;
    done_d     = done_q;
    pass_d     = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d    = StRun;
          cmdCnt_d   = '0;
          rspCnt_d   = '0;
          errCnt_d   = '0;
          firstErr_d = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      StRun: begin
        if (cmdFire) begin
          cmdCnt_d = cmdCnt_q + CntWidth'(1);
        end
        if (rspFire) begin
          rspCnt_d = rspCnt_q + CntWidth'(1);
          if (hdrFail) begin
            if (errCnt_q != '1) begin
              errCnt_d = errCnt_q + ErrCntWidth'(1);
            end
            if (errCnt_q == '0) begin
              firstErr_d = rspAddr;
            end
          end
          // The final count is already settled in errCnt_d, so pass can be registered with done.
          if (rspCnt_q == LastIdx) begin
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = (errCnt_d == '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign errorCount_o   = errCnt_q;
  assign firstErrAddr_o = firstErr_q;

endmodule
